// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared constants and counter-width helper for the switch debouncer
package switch_pkg;

  // Board clock and the default 10 ms debounce window at that clock
  localparam int unsigned CLK_FREQ_HZ             = 50_000_000;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500_000;

  // Counter width that can hold DEBOUNCE_CYCLES-1 (ceil(log2(n)), at least 1)
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/switch_debouncer_if.sv
// rtl/switch_debouncer_if.sv - switch/LED signal bundle between the DIP bank and the debouncer
interface switch_debouncer_if #(
  parameter int unsigned WIDTH = 4
);

  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] sw_db;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic [WIDTH-1:0] sw_toggle;

  // Switch side: drives raw levels, observes debounced results
  modport master (
    output sw,
    input  sw_db,
    input  sw_rise,
    input  sw_fall,
    input  sw_toggle
  );

  // Debouncer side
  modport slave (
    input  sw,
    output sw_db,
    output sw_rise,
    output sw_fall,
    output sw_toggle
  );

endinterface

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one switch channel: synchronizer, stability counter, level, edge pulses, toggle
// Optional push-on/push-off toggle flop: SWITCH_DEBOUNCER_TOGGLE_EN
module debounce_bit
  import switch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic sw_db,
  output logic sw_rise,
  output logic sw_fall,
  output logic sw_toggle
);

  localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync_q;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          accept;

  // The synchronized level disagrees with the accepted level; accept once it has for a full window
  assign differ = (sync_q != sw_db);
  assign accept = differ && (cnt == CNT_LAST);

  // Two-flop synchronizer: the raw switch is never used before this
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= sw;
      sync_q    <= sync_meta;
    end
  end

  // Stability counter and accepted level; any agreeing cycle restarts the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      sw_db   <= 1'b0;
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
    end else begin
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
      if (!differ) begin
        cnt <= '0;
      end else if (accept) begin
        cnt     <= '0;
        sw_db   <= sync_q;
        sw_rise <= sync_q;
        sw_fall <= ~sync_q;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
  // Push-on/push-off: flips on the same edge that raises sw_rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_toggle <= 1'b0;
    end else if (accept && sync_q) begin
      sw_toggle <= ~sw_toggle;
    end
  end
`else
  assign sw_toggle = 1'b0;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - WIDTH independent switch debouncers with edge pulses and optional toggle
// Optional toggle outputs: SWITCH_DEBOUNCER_TOGGLE_EN
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  switch_debouncer_if.slave   bus
);

  logic [WIDTH-1:0] db_v;
  logic [WIDTH-1:0] rise_v;
  logic [WIDTH-1:0] fall_v;
  logic [WIDTH-1:0] tog_v;

  // Each channel is fully independent; no state is shared between bits
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw        (bus.sw[i]),
      .sw_db     (db_v[i]),
      .sw_rise   (rise_v[i]),
      .sw_fall   (fall_v[i]),
      .sw_toggle (tog_v[i])
    );
  end

  assign bus.sw_db     = db_v;
  assign bus.sw_rise   = rise_v;
  assign bus.sw_fall   = fall_v;
  assign bus.sw_toggle = tog_v;

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - self-checking bench for switch_debouncer (WIDTH=4, DEBOUNCE_CYCLES=8)
// Toggle expectations follow SWITCH_DEBOUNCER_TOGGLE_EN
module tb_switch_debouncer;

  localparam int W  = 4;
  localparam int DC = 8;
  localparam int LAT = DC + 2;
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
  localparam bit TOG_EN = 1'b1;
`else
  localparam bit TOG_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  switch_debouncer_if #(.WIDTH(W)) sw_if ();

  switch_debouncer #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sw_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: level seen by the acceptance rule lags the pin by two edges;
  // a bit flips after DC consecutive disagreeing samples, any agreement restarts the run
  logic [W-1:0] m_d1, m_d2, m_use, m_lvl, m_rise, m_fall, m_tog;
  int           m_run [W];
  int           m_rise_total;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_d1 = '0; m_d2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0; m_tog = '0;
      for (int b = 0; b < W; b++) m_run[b] = 0;
    end else begin
      m_use = m_d2;
      m_d2  = m_d1;
      m_d1  = sw_if.sw;
      m_rise = '0;
      m_fall = '0;
      for (int b = 0; b < W; b++) begin
        if (m_use[b] != m_lvl[b]) begin
          m_run[b] = m_run[b] + 1;
          if (m_run[b] == DC) begin
            m_lvl[b]  = m_use[b];
            m_rise[b] = m_use[b];
            m_fall[b] = ~m_use[b];
            if (m_use[b]) m_rise_total = m_rise_total + 1;
            if (TOG_EN && m_use[b]) m_tog[b] = ~m_tog[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
    end
  end

  task automatic test_reset();
    int k;
    rst_n = 1'b0;
    sw_if.sw = 4'hF;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({sw_if.sw_db, sw_if.sw_rise, sw_if.sw_fall, sw_if.sw_toggle} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got db=%h rise=%h fall=%h tog=%h expected all 0",
               sw_if.sw_db, sw_if.sw_rise, sw_if.sw_fall, sw_if.sw_toggle);
    end
    rst_n = 1'b1;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sw_if.sw_db === 4'hF) begin k = i; break; end
    end
    n_cmp++;
    if (k != LAT) begin
      n_fail++; $display("FAIL reset_release_latency: got %0d edges expected %0d", k, LAT);
    end
    n_cmp++;
    if (sw_if.sw_rise !== 4'hF) begin
      n_fail++; $display("FAIL reset_release_rise: got %h expected f", sw_if.sw_rise);
    end
    n_cmp++;
    if (sw_if.sw_db !== m_lvl) begin
      n_fail++; $display("FAIL reset_model_db: got %h expected %h", sw_if.sw_db, m_lvl);
    end
    @(negedge clk);
    n_cmp++;
    if (sw_if.sw_rise !== 4'h0) begin
      n_fail++; $display("FAIL reset_rise_one_cycle: got %h expected 0", sw_if.sw_rise);
    end
    sw_if.sw = 4'h0;
    repeat (LAT + 2) @(negedge clk);
    n_cmp++;
    if (sw_if.sw_db !== 4'h0) begin
      n_fail++; $display("FAIL reset_return_low: got %h expected 0", sw_if.sw_db);
    end
  endtask

  task automatic test_glitch();
    sw_if.sw[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) sw_if.sw[0] = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({sw_if.sw_db, sw_if.sw_rise, sw_if.sw_fall} !== 12'h0) begin
        n_fail++;
        $display("FAIL glitch_rejected: cycle %0d got db=%h rise=%h fall=%h expected 0",
                 i, sw_if.sw_db, sw_if.sw_rise, sw_if.sw_fall);
      end
    end
  endtask

  task automatic test_bounce();
    int rises, falls, lat;
    rises = 0; falls = 0; lat = 0;
    for (int t = 0; t < 10; t++) begin
      sw_if.sw[1] = ~sw_if.sw[1];
      repeat (3) begin
        @(negedge clk);
        rises += int'(sw_if.sw_rise[1]);
        falls += int'(sw_if.sw_fall[1]);
      end
    end
    sw_if.sw[1] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sw_if.sw_rise[1] === 1'b1) begin
        rises++;
        if (lat == 0) lat = i;
      end
      falls += int'(sw_if.sw_fall[1]);
    end
    n_cmp++;
    if (lat != LAT) begin
      n_fail++; $display("FAIL bounce_latency: got %0d edges expected %0d", lat, LAT);
    end
    n_cmp++;
    if (rises != 1 || falls != 0) begin
      n_fail++; $display("FAIL bounce_pulses: got rises=%0d falls=%0d expected 1/0", rises, falls);
    end
    n_cmp++;
    if (sw_if.sw_db !== m_lvl || sw_if.sw_db[1] !== 1'b1) begin
      n_fail++; $display("FAIL bounce_db: got %h expected %h", sw_if.sw_db, m_lvl);
    end
  endtask

  task automatic test_release();
    int lat;
    lat = 0;
    sw_if.sw[2] = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    n_cmp++;
    if (sw_if.sw_db[2] !== 1'b1) begin
      n_fail++; $display("FAIL release_setup: got db[2]=%b expected 1", sw_if.sw_db[2]);
    end
    sw_if.sw[2] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sw_if.sw_fall[2] === 1'b1) begin lat = i; break; end
    end
    n_cmp++;
    if (lat != LAT || sw_if.sw_db[2] !== 1'b0) begin
      n_fail++; $display("FAIL release_fall: got %0d edges db[2]=%b expected %0d / 0", lat, sw_if.sw_db[2], LAT);
    end
    @(negedge clk);
    n_cmp++;
    if (sw_if.sw_fall[2] !== 1'b0 || sw_if.sw_rise[2] !== 1'b0) begin
      n_fail++; $display("FAIL release_one_cycle: got fall=%b rise=%b expected 0/0", sw_if.sw_fall[2], sw_if.sw_rise[2]);
    end
  endtask

  task automatic test_reset_mid();
    int pre, rises, lat;
    pre = 0; rises = 0; lat = 0;
    sw_if.sw[3] = 1'b1;
    repeat (7) begin
      @(negedge clk);
      pre += int'(sw_if.sw_rise[3]) + int'(sw_if.sw_db[3]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pre != 0 || {sw_if.sw_db, sw_if.sw_rise, sw_if.sw_fall, sw_if.sw_toggle} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got pre=%0d db=%h rise=%h expected 0", pre, sw_if.sw_db, sw_if.sw_rise);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sw_if.sw_rise[3] === 1'b1) begin
        rises++;
        if (lat == 0) lat = i;
      end
    end
    n_cmp++;
    if (lat != LAT || rises != 1) begin
      n_fail++; $display("FAIL reset_mid_rise: got lat=%0d rises=%0d expected %0d/1", lat, rises, LAT);
    end
    n_cmp++;
    if (sw_if.sw_db !== m_lvl || sw_if.sw_db[3] !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_db: got %h expected %h", sw_if.sw_db, m_lvl);
    end
  endtask

  task automatic test_toggle();
    logic [1:0] seen;
    n_cmp++;
    if (sw_if.sw_toggle[0] !== 1'b0) begin
      n_fail++; $display("FAIL toggle_start: got %b expected 0", sw_if.sw_toggle[0]);
    end
    for (int p = 0; p < 2; p++) begin
      sw_if.sw[0] = 1'b1;
      repeat (LAT + 2) @(negedge clk);
      seen[p] = sw_if.sw_toggle[0];
      n_cmp++;
      if (sw_if.sw_toggle !== m_tog) begin
        n_fail++; $display("FAIL toggle_model: press %0d got %h expected %h", p, sw_if.sw_toggle, m_tog);
      end
      sw_if.sw[0] = 1'b0;
      repeat (LAT + 2) @(negedge clk);
    end
    n_cmp++;
    if (seen !== {1'b0, TOG_EN}) begin
      n_fail++; $display("FAIL toggle_sequence: got after1=%b after2=%b expected %b/0", seen[0], seen[1], TOG_EN);
    end
  endtask

  task automatic test_random();
    int hold [W];
    int dut_rises;
    int m_start;
    dut_rises = 0;
    m_start = m_rise_total;
    for (int b = 0; b < W; b++) hold[b] = 0;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      dut_rises += $countones(sw_if.sw_rise);
      n_cmp++;
      if (sw_if.sw_db !== m_lvl || sw_if.sw_rise !== m_rise || sw_if.sw_fall !== m_fall ||
          sw_if.sw_toggle !== m_tog) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: got db=%h rise=%h fall=%h tog=%h expected %h %h %h %h",
                 c, sw_if.sw_db, sw_if.sw_rise, sw_if.sw_fall, sw_if.sw_toggle,
                 m_lvl, m_rise, m_fall, m_tog);
      end
      n_cmp++;
      if ((sw_if.sw_rise & sw_if.sw_fall) !== 4'h0) begin
        n_fail++; $display("FAIL random_rise_and_fall: got %h expected 0", sw_if.sw_rise & sw_if.sw_fall);
      end
      for (int b = 0; b < W; b++) begin
        if (hold[b] == 0) begin
          sw_if.sw[b] = 1'($urandom_range(0, 1));
          hold[b] = int'($urandom_range(1, 14));
        end else begin
          hold[b]--;
        end
      end
    end
    n_cmp++;
    if (dut_rises != m_rise_total - m_start || dut_rises == 0) begin
      n_fail++; $display("FAIL random_rise_count: got %0d expected %0d (nonzero)", dut_rises, m_rise_total - m_start);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    m_rise_total = 0;
    rst_n = 1'b0;
    sw_if.sw = '0;
    test_reset();
    test_glitch();
    test_bounce();
    test_release();
    test_reset_mid();
    test_toggle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the number of independent switch channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), the consecutive stable cycles required to accept a new level; legal range 2..2^24.
REQ-003 SHALL have port CLK, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have port SW, input, WIDTH bits, raw asynchronous DIP-switch levels.
REQ-006 SHALL have port SW_DB, output, WIDTH bits, debounced registered levels that drive the LED stage.
REQ-007 SHALL have port SW_RISE, output, WIDTH bits, a one-cycle pulse per bit when SW_DB goes 0->1.
REQ-008 SHALL have port SW_FALL, output, WIDTH bits, a one-cycle pulse per bit when SW_DB goes 1->0.
REQ-009 SHALL have port SW_TOGGLE, output, WIDTH bits, per-bit toggle state (see Configuration).

Function
REQ-010 SHALL pass each SW bit through a two-flop synchronizer before any other use; no combinational path from SW to any output.
REQ-011 SHALL keep one counter per bit, ceil(log2(DEBOUNCE_CYCLES)) bits wide, saturating-free (it never exceeds DEBOUNCE_CYCLES-1).
REQ-012 SHALL increment a bit's counter on each cycle its synchronized value differs from its SW_DB bit.
REQ-013 SHALL clear a bit's counter to 0 on any cycle its synchronized value equals its SW_DB bit (glitch rejection restarts the count).
REQ-014 SHALL, on the cycle the counter equals DEBOUNCE_CYCLES-1 while still differing, load SW_DB bit with the synchronized value and clear the counter.
REQ-015 SHALL give a total latency of exactly DEBOUNCE_CYCLES+2 rising edges from the first edge sampling a steady new SW level to the edge updating SW_DB.
REQ-016 SHALL assert SW_RISE/SW_FALL in the same cycle SW_DB changes, for exactly one cycle, never both on the same bit.
REQ-017 SHALL process bits fully independently; simultaneous changes on several bits produce simultaneous, independent pulses.
REQ-018 SHALL reject any pulse or bounce shorter than DEBOUNCE_CYCLES synchronized cycles with no output change.

Reset
REQ-019 SHALL, while RST_N is low, force synchronizer flops, counters, SW_DB, SW_RISE, SW_FALL and SW_TOGGLE to 0.
REQ-020 SHALL, on reset mid-count, discard the count; after release a held-high switch is accepted after DEBOUNCE_CYCLES+2 edges and produces one SW_RISE.
REQ-021 SHALL register all outputs; no output is decoded combinationally from counters.

Configuration
REQ-022 SHALL, with macro SWITCH_DEBOUNCER_TOGGLE_EN defined, flip each SW_TOGGLE bit on every SW_RISE of that bit (push-on/push-off).
REQ-023 SHALL, without SWITCH_DEBOUNCER_TOGGLE_EN, tie SW_TOGGLE to constant 0 and instantiate no toggle flops; the port list is unchanged.

Structure
REQ-024 SHALL place the default DEBOUNCE_CYCLES value, the board clock frequency constant (50_000_000) and the counter-width function in shared package switch_pkg.
REQ-025 SHALL implement one channel (synchronizer, counter, level, edge pulses, toggle) in sub-module debounce_bit, instantiated WIDTH times via generate.
REQ-026 SHALL fit in 120-400 lines of RTL in total.

Verification (bench uses DEBOUNCE_CYCLES=8, WIDTH=4)
REQ-027 SHALL verify reset: RST_N=0 with SW=4'hF -> all outputs 0; release -> SW_DB=4'hF exactly 10 edges later with SW_RISE=4'hF for one cycle.
REQ-028 SHALL verify glitch rejection: SW[0] high for 5 cycles then low -> SW_DB, SW_RISE and SW_FALL stay 0.
REQ-029 SHALL verify bounce: SW[1] toggles every 3 cycles for 30 cycles then holds 1 -> single SW_RISE[1] 10 edges after the last transition.
REQ-030 SHALL verify release: SW_DB[2]=1, SW[2]->0 held -> SW_FALL[2] one cycle, SW_DB[2]=0 after 10 edges.
REQ-031 SHALL verify reset mid-count: RST_N pulsed low at count 5 on SW[3] -> no pulse; SW_DB[3] rises 10 edges after release.
REQ-032 SHALL verify toggle: with SWITCH_DEBOUNCER_TOGGLE_EN, two accepted presses on SW[0] -> SW_TOGGLE[0] 0->1->0; without the macro, SW_TOGGLE stays 4'h0.
